// File: rtl/sub_16bit_pipe_pkg.sv
// Shared arithmetic definitions for the pipelined subtractor: default geometry,
// stage-count derivation and the per-stage record layout.
package sub_16bit_pipe_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 4;

  function automatic int stages_of(input int width, input int slice);
    return width / slice;
  endfunction

  localparam int STAGES_DEF = stages_of(WIDTH_DEF, SLICE_DEF);

  // Contents of one stage register at the default geometry.
  typedef struct packed {
    logic                 valid;
    logic [WIDTH_DEF-1:0] pdiff;
    logic [WIDTH_DEF-1:0] a_rem;
    logic [WIDTH_DEF-1:0] b_rem;
    logic                 borrow;
    logic                 a_sign;
    logic                 b_sign;
  } stage_rec_t;

endpackage

// File: rtl/sub_slice.sv
// Combinational SLICE-bit subtract with borrow in/out: {o_bout, o_d} = i_a - i_b - i_bin.
module sub_slice
  import sub_16bit_pipe_pkg::*;
#(
  parameter int SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_bin,
  output logic [SLICE-1:0] o_d,
  output logic             o_bout
);

  logic [SLICE:0] w_full;

  // One extra bit catches the borrow: the result goes negative iff a < b + bin.
  assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{SLICE{1'b0}}, i_bin};
  assign o_d    = w_full[SLICE-1:0];
  assign o_bout = w_full[SLICE];

endmodule

// File: rtl/sub_16bit_pipe.sv
// Pipelined subtractor: stage k resolves diff slice k, with a single global stall
// enable so the whole pipe freezes while the consumer holds off.
module sub_16bit_pipe
  import sub_16bit_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int STAGES = stages_of(WIDTH, SLICE);

  logic             w_en;
  logic             r_valid  [STAGES];
  logic [WIDTH-1:0] r_a      [STAGES];
  logic [WIDTH-1:0] r_b      [STAGES];
  logic [WIDTH-1:0] r_pdiff  [STAGES];
  logic             r_borrow [STAGES];
  logic [SLICE-1:0] w_d      [STAGES];
  logic             w_bo     [STAGES];
  logic [WIDTH-1:0] w_pdiff  [STAGES];

  logic             r_out_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_a_sign;
  logic             w_b_sign;
  logic             w_d_sign;

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi = gi + 1) begin : g_stage
      localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}}) << (gi * SLICE);

      sub_slice #(.SLICE(SLICE)) u_slice (
        .i_a    (r_a[gi][gi*SLICE +: SLICE]),
        .i_b    (r_b[gi][gi*SLICE +: SLICE]),
        .i_bin  (r_borrow[gi]),
        .o_d    (w_d[gi]),
        .o_bout (w_bo[gi])
      );

      // Drop this stage's slice into its final bit position of the partial diff.
      assign w_pdiff[gi] = (r_pdiff[gi] & ~SLICE_MASK) | (WIDTH'(w_d[gi]) << (gi * SLICE));
    end
  endgenerate

  // Operand sign bits ride along inside the carried operands to the last stage.
  assign w_a_sign = r_a[STAGES-1][WIDTH-1];
  assign w_b_sign = r_b[STAGES-1][WIDTH-1];
  assign w_d_sign = w_pdiff[STAGES-1][WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k]  <= 1'b0;
        r_a[k]      <= '0;
        r_b[k]      <= '0;
        r_pdiff[k]  <= '0;
        r_borrow[k] <= 1'b0;
      end
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_en) begin
      r_valid[0]  <= in_valid && in_ready;
      r_a[0]      <= a;
      r_b[0]      <= b;
      r_pdiff[0]  <= '0;
      r_borrow[0] <= bin;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k]  <= r_valid[k-1];
        r_a[k]      <= r_a[k-1];
        r_b[k]      <= r_b[k-1];
        r_pdiff[k]  <= w_pdiff[k-1];
        r_borrow[k] <= w_bo[k-1];
      end
      r_out_valid <= r_valid[STAGES-1];
      // Bubbles leave the result registers untouched.
      if (r_valid[STAGES-1]) begin
        r_diff <= w_pdiff[STAGES-1];
        r_bout <= w_bo[STAGES-1];
        r_ovf  <= (w_a_sign != w_b_sign) && (w_d_sign != w_a_sign);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_sub_16bit_pipe.sv
// Self-checking bench for sub_16bit_pipe: directed corner cases, backpressure,
// random streaming and mid-stream reset against a plain-arithmetic reference.
module tb_sub_16bit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  sub_16bit_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {bout, overflow, diff} from integer arithmetic on the operand values.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    int u;
    int s;
    logic [15:0] d;
    logic bo;
    logic ov;
    u  = int'(x) - int'(y) - int'(c);
    s  = int'($signed(x)) - int'($signed(y)) - int'(c);
    d  = u[15:0];
    bo = (u < 0);
    ov = (s > 32767) || (s < -32768);
    return {bo, ov, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_single(input string tag, input logic [15:0] ta, input logic [15:0] tb2,
                            input logic tc, input bit now);
    int lat;
    if (!now) @(negedge clk);
    a = ta; b = tb2; bin = tc; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'd4);
    chk({tag, " result"}, 32'({bout, overflow, diff}), 32'(model(ta, tb2, tc)));
    $display("single %s: a=%h b=%h bin=%0d -> diff=%h bout=%0d ovf=%0d lat=%0d",
             tag, ta, tb2, tc, diff, bout, overflow, lat);
  endtask

  // rand_mode=0: full-rate stream with one 3-cycle stall on the first result.
  // rand_mode=1: random in_valid gaps and random out_ready.
  task automatic stream(input string tag, input int n, input bit rand_mode);
    logic [17:0] q[$];
    logic [17:0] e;
    logic [17:0] snap;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!rand_mode && !stalled && out_valid) begin
        stalled = 1'b1;
        stall_left = 3;
        snap = {bout, overflow, diff};
      end
      out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : (stall_left == 0);
      in_valid  = (sent < n) && (!rand_mode || $urandom_range(0, 3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      bin = 1'($urandom);
      #1;
      if (stall_left > 0) begin
        chk({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, " stall hold"}, 32'({out_valid, bout, overflow, diff}), 32'({1'b1, snap}));
        stall_left--;
      end else if (!rand_mode && sent < n) begin
        chk({tag, " full-rate in_ready"}, 32'(in_ready), 32'd1);
      end
      if (out_valid && out_ready) begin
        chk({tag, " result expected"}, 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk({tag, " result"}, 32'({bout, overflow, diff}), 32'(e));
          $display("stream %s #%0d: diff=%h bout=%0d ovf=%0d expect=%h",
                   tag, got, diff, bout, overflow, e);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, bin));
        sent++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, " result count"}, 32'(got), 32'(n));
    chk({tag, " leftover"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int extra;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset outputs", 32'({bout, overflow, diff}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_single("5-3", 16'h0005, 16'h0003, 1'b0, 1'b0);
    run_single("0-1 ripple", 16'h0000, 16'h0001, 1'b0, 1'b0);
    run_single("8000-1 ovf", 16'h8000, 16'h0001, 1'b0, 1'b0);
    run_single("7FFF-FFFF ovf", 16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
    run_single("1234-1234-1", 16'h1234, 16'h1234, 1'b1, 1'b0);

    stream("backpressure", 8, 1'b0);
    stream("random", 30, 1'b1);

    // Three beats in flight, then a one-cycle reset.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("in_ready during rst", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("post-rst out_valid", 32'(out_valid), 32'd0);
    chk("post-rst outputs", 32'({bout, overflow, diff}), 32'd0);
    run_single("post-rst beat", 16'h4321, 16'h1234, 1'b1, 1'b1);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("no stale results", 32'(extra), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
